// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 VGA timing generator that scans a 256x240 frame buffer
// out at 2x scale, centred horizontally, with a 2-cycle aligned sync/de/pixel pipeline.
//
// Ports:
//   clk            pixel clock, one VGA pixel per cycle
//   rst            synchronous active-low reset
//   test_mode      (VGA_TEST_PATTERN_EN only) colour bars instead of memory
//   vga_read_row   frame-buffer row address (0..239), combinational from counters
//   vga_read_col   frame-buffer column address (0..255), combinational from counters
//   vga_read_data  frame-buffer data, valid one cycle after the address
//   vga_done       high while the frame buffer is not being read (vertical blank)
//   hsync, vsync   active-low syncs, registered
//   de             display enable, registered
//   pixel_idx      colour index, registered
//
// Optional feature macro: VGA_TEST_PATTERN_EN (adds test_mode and 8 colour bars).
// Vertical timing is parameterised in lines; the defaults give standard 640x480.

module vga_scanout #(
    parameter int unsigned H_OFFSET   = 64,
    parameter logic [7:0]  BORDER_IDX = 8'h00,
    parameter int unsigned V_VISIBLE  = 480,
    parameter int unsigned V_FRONT    = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BACK     = 33
) (
    input  logic       clk,
    input  logic       rst,
`ifdef VGA_TEST_PATTERN_EN
    input  logic       test_mode,
`endif
    output logic [9:0] vga_read_row,
    output logic [9:0] vga_read_col,
    input  logic [7:0] vga_read_data,
    output logic       vga_done,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [7:0] pixel_idx
);

    localparam int unsigned H_VISIBLE    = 640;
    localparam int unsigned H_FRONT      = 16;
    localparam int unsigned H_SYNC       = 96;
    localparam int unsigned H_BACK       = 48;
    localparam int unsigned H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int unsigned V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;
    localparam int unsigned IMG_W        = 512;
    localparam int unsigned CNT_W        = 10;

    // Counter state
    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic             done_q, done_d;

    // Stage 1: timing decoded from counters, aligned with memory read latency
    logic             s1_hs_q, s1_vs_q, s1_de_q, s1_win_q;
    logic             s1_hs_d, s1_vs_d, s1_de_d;
`ifdef VGA_TEST_PATTERN_EN
    logic             s1_tm_q;
    logic [2:0]       s1_bar_q;
`endif

    // Stage 2: output registers
    logic             hsync_q, vsync_q, de_q;
    logic [7:0]       pix_q, pix_d;

    // Combinational decode
    logic             h_last_c, v_last_c;
    logic             win_c;
    logic [8:0]       img_col_c;

    // Counter advance and wrap
    always_comb begin
        h_last_c = (h_q == CNT_W'(H_TOTAL - 1));
        v_last_c = (v_q == CNT_W'(V_TOTAL - 1));
        h_d      = h_q + CNT_W'(1);
        v_d      = v_q;
        if (h_last_c) begin
            h_d = '0;
            v_d = v_last_c ? '0 : v_q + CNT_W'(1);
        end
    end

    // Image window and read address; gated by rst so addresses are 0 in reset
    always_comb begin
        win_c     = rst
                    && (h_q >= CNT_W'(H_OFFSET))
                    && (h_q <  CNT_W'(H_OFFSET + IMG_W))
                    && (v_q <  CNT_W'(V_VISIBLE));
        img_col_c = 9'((h_q - CNT_W'(H_OFFSET)) >> 1);
        vga_read_row = '0;
        vga_read_col = '0;
        if (win_c) begin
            vga_read_row = {1'b0, v_q[CNT_W-1:1]};
            vga_read_col = {1'b0, img_col_c};
        end
    end

    // Raw sync/de from counter state
    always_comb begin
        s1_hs_d = !((h_q >= CNT_W'(H_SYNC_START)) && (h_q <= CNT_W'(H_SYNC_END)));
        s1_vs_d = !((v_q >= CNT_W'(V_SYNC_START)) && (v_q <= CNT_W'(V_SYNC_END)));
        s1_de_d = (h_q < CNT_W'(H_VISIBLE)) && (v_q < CNT_W'(V_VISIBLE));
    end

    // vga_done: set after the last visible line's final read, cleared at frame wrap
    always_comb begin
        done_d = done_q;
        if (h_last_c && (v_q == CNT_W'(V_VISIBLE - 1))) begin
            done_d = 1'b1;
        end else if (h_last_c && v_last_c) begin
            done_d = 1'b0;
        end
    end

    // Pixel select: data arrives alongside stage-1 timing
    always_comb begin
        pix_d = '0;
        if (s1_de_q) begin
            if (s1_win_q) begin
`ifdef VGA_TEST_PATTERN_EN
                pix_d = s1_tm_q ? {5'd0, s1_bar_q} : vga_read_data;
`else
                pix_d = vga_read_data;
`endif
            end else begin
                pix_d = BORDER_IDX;
            end
        end
    end

    // Counters, vga_done and both pipeline stages
    always_ff @(posedge clk) begin
        if (!rst) begin
            h_q      <= '0;
            v_q      <= '0;
            done_q   <= 1'b0;
            s1_hs_q  <= 1'b1;
            s1_vs_q  <= 1'b1;
            s1_de_q  <= 1'b0;
            s1_win_q <= 1'b0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            de_q     <= 1'b0;
            pix_q    <= '0;
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            done_q   <= done_d;
            s1_hs_q  <= s1_hs_d;
            s1_vs_q  <= s1_vs_d;
            s1_de_q  <= s1_de_d;
            s1_win_q <= win_c;
            hsync_q  <= s1_hs_q;
            vsync_q  <= s1_vs_q;
            de_q     <= s1_de_q;
            pix_q    <= pix_d;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    // Bar number = source column / 32, carried alongside the memory read
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_tm_q  <= 1'b0;
            s1_bar_q <= '0;
        end else begin
            s1_tm_q  <= test_mode;
            s1_bar_q <= img_col_c[7:5];
        end
    end
`endif

    assign vga_done  = done_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign de        = de_q;
    assign pixel_idx = pix_q;

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: self-checking bench for vga_scanout with a shortened vertical
// frame (15 lines) so several frames fit in a short run. A reference model
// computes every output from the cycle count since reset release.

module tb_vga_scanout;

    localparam int VV     = 8;
    localparam int VF     = 2;
    localparam int VS     = 2;
    localparam int VB     = 3;
    localparam int VT     = VV + VF + VS + VB;
    localparam int LINE   = 800;
    localparam int FRAME  = LINE * VT;
    localparam int HOFF   = 64;
    localparam logic [7:0] BORDER = 8'hB5;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic       done;
        logic [7:0] pix;
    } obs_t;

    typedef struct {
        int   k;
        obs_t exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tm  = 1'b0;
    logic [9:0] vga_read_row, vga_read_col;
    logic [7:0] rdata;
    logic       vga_done, hsync, vsync, de;
    logic [7:0] pixel_idx;

    logic [7:0] mem [0:255][0:255];

    int   checks = 0;
    int   errors = 0;
    int   k = 0;
    bit   tbl_on = 1'b0;
    bit   cnt_on = 1'b0;
    int   tp = 0;
    int   hs_low = 0, vs_low = 0, done_hi = 0;
    vec_t tbl[$];

    vga_scanout #(
        .H_OFFSET   (HOFF),
        .BORDER_IDX (BORDER),
        .V_VISIBLE  (VV),
        .V_FRONT    (VF),
        .V_SYNC     (VS),
        .V_BACK     (VB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode     (tm),
`endif
        .vga_read_row  (vga_read_row),
        .vga_read_col  (vga_read_col),
        .vga_read_data (rdata),
        .vga_done      (vga_done),
        .hsync         (hsync),
        .vsync         (vsync),
        .de            (de),
        .pixel_idx     (pixel_idx)
    );

    always #5 clk = ~clk;

    // Synchronous frame-buffer: data one cycle after address
    always @(posedge clk) rdata <= mem[8'(vga_read_row)][8'(vga_read_col)];

    // Expected registered outputs kk cycles after release (kk=0 also covers reset)
    function automatic obs_t model_out(input int kk);
        obs_t o;
        int   st, h, v;
        o.hs   = 1'b1;
        o.vs   = 1'b1;
        o.de   = 1'b0;
        o.pix  = 8'h00;
        o.done = (((kk / LINE) % VT) >= VV);
        if (kk >= 2) begin
            st   = kk - 2;
            h    = st % LINE;
            v    = (st / LINE) % VT;
            o.hs = !(h >= 656 && h < 752);
            o.vs = !(v >= VV + VF && v < VV + VF + VS);
            o.de = (h < 640) && (v < VV);
            if (o.de) begin
                if (h >= HOFF && h < HOFF + 512)
                    o.pix = tm ? 8'((h - HOFF) / 64) : mem[v / 2][(h - HOFF) / 2];
                else
                    o.pix = BORDER;
            end
        end
        return o;
    endfunction

    function automatic logic [19:0] model_addr(input int kk);
        int h, v;
        h = kk % LINE;
        v = (kk / LINE) % VT;
        if (h >= HOFF && h < HOFF + 512 && v < VV)
            return {10'(v / 2), 10'((h - HOFF) / 2)};
        return 20'd0;
    endfunction

    task automatic chk(input string name, input int kk, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s k=%0d got=%h expected=%h", name, kk, got, exp);
        end
    endtask

    task automatic add(input int kk, input logic hs, input logic vs, input logic de_e,
                       input logic [7:0] pix, input logic done);
        vec_t e;
        e.k        = kk;
        e.exp.hs   = hs;
        e.exp.vs   = vs;
        e.exp.de   = de_e;
        e.exp.done = done;
        e.exp.pix  = pix;
        tbl.push_back(e);
    endtask

    // One clock: sample rst at the edge, check everything on the falling edge
    task automatic tick();
        logic r;
        obs_t got;
        @(posedge clk);
        r = rst;
        @(negedge clk);
        if (r) k++; else k = 0;
        got = {hsync, vsync, de, vga_done, pixel_idx};
        chk("outputs", k, 32'(got), 32'(model_out(k)));
        chk("address", k, 32'({vga_read_row, vga_read_col}), 32'(model_addr(k)));
        if (tbl_on && tp < tbl.size() && tbl[tp].k == k) begin
            chk("table", k, 32'(got), 32'(tbl[tp].exp));
            tp++;
        end
        if (cnt_on && k >= 2 && k < 2 + 2 * FRAME) begin
            if (!hsync)  hs_low++;
            if (!vsync)  vs_low++;
            if (vga_done) done_hi++;
        end
    endtask

    task automatic run_to_phase(input int phase);
        for (int n = 0; n < 2 * FRAME && (k % FRAME) != phase; n++) tick();
        chk("phase_reached", k, 32'(k % FRAME), 32'(phase));
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            for (int j = 0; j < 256; j++)
                mem[i][j] = 8'($urandom);
        mem[0][0]        = 8'h21;
        mem[0][1]        = 8'h22;
        mem[VV/2-1][255] = 8'h3F;

        //   k      hs  vs  de  pix     done
        add(0,     1, 1, 0, 8'h00, 0);
        add(1,     1, 1, 0, 8'h00, 0);
        add(2,     1, 1, 1, BORDER, 0);
        add(65,    1, 1, 1, BORDER, 0);
        add(66,    1, 1, 1, 8'h21, 0);
        add(67,    1, 1, 1, 8'h21, 0);
        add(68,    1, 1, 1, 8'h22, 0);
        add(69,    1, 1, 1, 8'h22, 0);
        add(642,   1, 1, 0, 8'h00, 0);
        add(657,   1, 1, 0, 8'h00, 0);
        add(658,   0, 1, 0, 8'h00, 0);
        add(753,   0, 1, 0, 8'h00, 0);
        add(754,   1, 1, 0, 8'h00, 0);
        add(802,   1, 1, 1, BORDER, 0);
        add(866,   1, 1, 1, 8'h21, 0);
        add(867,   1, 1, 1, 8'h21, 0);
        add(868,   1, 1, 1, 8'h22, 0);
        add(869,   1, 1, 1, 8'h22, 0);
        add(5376,  1, 1, 1, 8'h3F, 0);
        add(5377,  1, 1, 1, 8'h3F, 0);
        add(6176,  1, 1, 1, 8'h3F, 0);
        add(6177,  1, 1, 1, 8'h3F, 0);
        add(6178,  1, 1, 1, BORDER, 0);
        add(6399,  1, 1, 0, 8'h00, 0);
        add(6400,  1, 1, 0, 8'h00, 1);
        add(8001,  1, 1, 0, 8'h00, 1);
        add(8002,  1, 0, 0, 8'h00, 1);
        add(9601,  1, 0, 0, 8'h00, 1);
        add(9602,  1, 1, 0, 8'h00, 1);
        add(11999, 1, 1, 0, 8'h00, 1);
        add(12000, 1, 1, 0, 8'h00, 0);
        add(12002, 1, 1, 1, BORDER, 0);
        add(12066, 1, 1, 1, 8'h21, 0);

        // Reset, then two full frames against the table and the model
        rst    = 1'b0;
        tbl_on = 1'b1;
        cnt_on = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        for (int n = 0; n < 3 * FRAME && k < 2 * FRAME + 5; n++) tick();
        tbl_on = 1'b0;
        cnt_on = 1'b0;
        chk("table_consumed", k, 32'(tp), 32'(tbl.size()));
        chk("hsync_low_cycles", k, 32'(hs_low), 32'(2 * VT * 96));
        chk("vsync_low_cycles", k, 32'(vs_low), 32'(2 * VS * LINE));
        chk("done_high_cycles", k, 32'(done_hi), 32'(2 * (VT - VV) * LINE));

        // Mid-frame reset for 5 cycles; first hsync low 656 counter cycles + 2 pipeline after release
        run_to_phase(5 * LINE + 100);
        rst = 1'b0;
        repeat (5) tick();
        chk("reset_outputs", k, 32'({hsync, vsync, de, vga_done, pixel_idx}), 32'({4'b1100, 8'h00}));
        rst = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            tick();
            if (!hsync) break;
        end
        chk("hsync_after_reset", k, 32'(k), 32'(658));

        // Reset during vertical blank clears vga_done
        run_to_phase((VV + 1) * LINE + 50);
        chk("done_before_reset", k, 32'(vga_done), 32'(1));
        rst = 1'b0;
        repeat (2) tick();
        chk("done_in_reset", k, 32'(vga_done), 32'(0));
        rst = 1'b1;

        // Random reset points and lengths
        for (int it = 0; it < 4; it++) begin
            int n_run, n_rst;
            n_run = int'($urandom_range(100, 6000));
            n_rst = int'($urandom_range(1, 6));
            repeat (n_run) tick();
            rst = 1'b0;
            repeat (n_rst) tick();
            rst = 1'b1;
        end
        repeat (LINE * 2) tick();

`ifdef VGA_TEST_PATTERN_EN
        // Colour bars: 8 bars of 64 output pixels starting at column 64
        rst = 1'b0;
        tick();
        tm = 1'b1;
        tick();
        rst = 1'b1;
        for (int n = 0; n < LINE + 10; n++) begin
            tick();
            if (k == 2 + 64)  chk("bar0_start", k, 32'(pixel_idx), 32'(0));
            if (k == 2 + 127) chk("bar0_end",   k, 32'(pixel_idx), 32'(0));
            if (k == 2 + 128) chk("bar1_start", k, 32'(pixel_idx), 32'(1));
            if (k == 2 + 512) chk("bar7_start", k, 32'(pixel_idx), 32'(7));
            if (k == 2 + 575) chk("bar7_end",   k, 32'(pixel_idx), 32'(7));
            if (k == 2 + 576) chk("bar_border", k, 32'(pixel_idx), 32'(BORDER));
        end
        rst = 1'b0;
        tick();
        tm = 1'b0;
        tick();
        rst = 1'b1;
        repeat (LINE) tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
